// File: rtl/uart_regbridge_pkg.sv
// Shared types and byte codes for the UART register bridge.
// Optional inter-byte timeout is enabled with UART_REGBRIDGE_TIMEOUT_EN.
package uart_regbridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RESP
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

endpackage

// File: rtl/uart_regbridge_tmr.sv
// Loadable, clearable cycle counter; o_tc is high on the TERM-th counted cycle.
// Counter saturates at the terminal count until cleared or loaded.
module uart_regbridge_tmr #(
    parameter int unsigned TERM = 64,
    parameter int unsigned W    = $clog2(TERM + 1)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= i_load_val;
        end else if (i_en && !o_tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    // cnt starts at zero on the first counted cycle, so TERM-1 marks the TERM-th.
    assign o_tc = (cnt == W'(TERM - 1));

endmodule

// File: rtl/uart_regbridge.sv
// UART byte-stream to register-bus bridge: 0x57 addr data writes, 0x52 addr reads, one reply byte per frame.
// Optional inter-byte frame timeout is enabled with UART_REGBRIDGE_TIMEOUT_EN.
module uart_regbridge
    import uart_regbridge_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT  = 50000,
    parameter int unsigned BUS_TIMEOUT = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_valid,
    output logic       o_rx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_bus_req,
    output logic       o_bus_we,
    output logic [7:0] o_bus_addr,
    output logic [7:0] o_bus_wdata,
    input  logic       i_bus_ack,
    input  logic [7:0] i_bus_rdata,
    output logic       o_frame_err
);

    state_t state;
    logic   bus_tc;
    logic   rx_drop;

    assign o_rx_ready = (state == ST_IDLE) || (state == ST_ADDR) || (state == ST_DATA);

    uart_regbridge_tmr #(.TERM(BUS_TIMEOUT)) u_bus_tmr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (state != ST_BUS),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (state == ST_BUS),
        .o_tc       (bus_tc)
    );

`ifdef UART_REGBRIDGE_TIMEOUT_EN
    logic in_frame;
    logic rx_tc;

    assign in_frame = (state == ST_ADDR) || (state == ST_DATA);

    uart_regbridge_tmr #(.TERM(RX_TIMEOUT)) u_rx_tmr (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (!in_frame || i_rx_valid),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (in_frame),
        .o_tc       (rx_tc)
    );

    assign rx_drop = in_frame && !i_rx_valid && rx_tc;
`else
    assign rx_drop = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state       <= ST_IDLE;
            o_tx_data   <= 8'h00;
            o_tx_valid  <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 8'h00;
            o_bus_wdata <= 8'h00;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_WR || i_rx_data == CMD_RD) begin
                            o_bus_we <= (i_rx_data == CMD_WR);
                            state    <= ST_ADDR;
                        end else begin
                            o_tx_data   <= RSP_NAK;
                            o_tx_valid  <= 1'b1;
                            o_frame_err <= 1'b1;
                            state       <= ST_RESP;
                        end
                    end
                end
                ST_ADDR: begin
                    if (i_rx_valid) begin
                        o_bus_addr <= i_rx_data;
                        if (o_bus_we) begin
                            state <= ST_DATA;
                        end else begin
                            o_bus_req <= 1'b1;
                            state     <= ST_BUS;
                        end
                    end else if (rx_drop) begin
                        o_frame_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (i_rx_valid) begin
                        o_bus_wdata <= i_rx_data;
                        o_bus_req   <= 1'b1;
                        state       <= ST_BUS;
                    end else if (rx_drop) begin
                        o_frame_err <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                ST_BUS: begin
                    // An ack on the final allowed cycle takes priority over the timeout.
                    if (i_bus_ack) begin
                        o_bus_req  <= 1'b0;
                        o_tx_data  <= o_bus_we ? RSP_ACK : i_bus_rdata;
                        o_tx_valid <= 1'b1;
                        state      <= ST_RESP;
                    end else if (bus_tc) begin
                        o_bus_req   <= 1'b0;
                        o_tx_data   <= RSP_NAK;
                        o_tx_valid  <= 1'b1;
                        o_frame_err <= 1'b1;
                        state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_regbridge.sv
// Randomized frame-level bench for uart_regbridge with a timeline model and per-cycle compare.
module tb_uart_regbridge;

    localparam int BT  = 8;
    localparam int RXT = 100;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic       o_rx_ready;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_bus_req;
    logic       o_bus_we;
    logic [7:0] o_bus_addr;
    logic [7:0] o_bus_wdata;
    logic       i_bus_ack;
    logic [7:0] i_bus_rdata;
    logic       o_frame_err;

    always #5 clk = ~clk;

    uart_regbridge #(.RX_TIMEOUT(RXT), .BUS_TIMEOUT(BT)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_valid  (i_rx_valid),
        .o_rx_ready  (o_rx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata),
        .o_frame_err (o_frame_err)
    );

    int npass = 0;
    int ntot  = 0;

    // Model of what the outputs must be during the current cycle.
    logic       chk_en = 1'b0;
    logic       exp_req = 1'b0, exp_we = 1'b0, exp_tx_valid = 1'b0, exp_err = 1'b0;
    logic [7:0] exp_addr = '0, exp_wdata = '0, exp_tx_data = '0;

    // Observations used by the literal pins.
    int         req_cycles = 0;
    int         err_pulses = 0;
    logic       obs_we = 1'b0;
    logic [7:0] obs_addr = '0, obs_wdata = '0, last_tx = '0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        ntot++;
        if (act === req) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rx_ready", {7'd0, o_rx_ready}, {7'd0, !exp_req && !exp_tx_valid});
            check("bus_req", {7'd0, o_bus_req}, {7'd0, exp_req});
            if (exp_req) begin
                check("bus_we", {7'd0, o_bus_we}, {7'd0, exp_we});
                check("bus_addr", o_bus_addr, exp_addr);
                if (exp_we) check("bus_wdata", o_bus_wdata, exp_wdata);
            end
            check("tx_valid", {7'd0, o_tx_valid}, {7'd0, exp_tx_valid});
            if (exp_tx_valid) check("tx_data", o_tx_data, exp_tx_data);
            check("frame_err", {7'd0, o_frame_err}, {7'd0, exp_err});
            if (o_bus_req) begin
                req_cycles++;
                obs_we    = o_bus_we;
                obs_addr  = o_bus_addr;
                obs_wdata = o_bus_wdata;
            end
            if (o_tx_valid && i_tx_ready) last_tx = o_tx_data;
            if (o_frame_err) err_pulses++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_err = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom);
    endtask

    // Idle cycles with stray ack / tx_ready noise, which the bridge must ignore.
    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            i_bus_ack   = ($urandom_range(0, 3) == 0);
            i_bus_rdata = 8'($urandom);
            i_tx_ready  = 1'($urandom);
            tick();
            i_bus_ack  = 1'b0;
            i_tx_ready = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] wdata,
                             input int lat, input logic [7:0] rdata, input int hold, input int gfix);
        logic wr;
        wr = (cmd == 8'h57);
        send_byte(cmd);
        if (cmd != 8'h57 && cmd != 8'h52) begin
            exp_tx_valid = 1'b1;
            exp_tx_data  = 8'h15;
            exp_err      = 1'b1;
        end else begin
            gap(gfix > 0 ? gfix : $urandom_range(0, 2));
            send_byte(addr);
            if (wr) begin
                gap($urandom_range(0, 2));
                send_byte(wdata);
            end
            exp_req = 1'b1; exp_we = wr; exp_addr = addr; exp_wdata = wdata;
            for (int c = 1; c <= BT; c++) begin
                if (c == lat) begin
                    i_bus_ack   = 1'b1;
                    i_bus_rdata = rdata;
                end
                tick();
                i_bus_ack   = 1'b0;
                i_bus_rdata = 8'($urandom);
                if (c == lat) begin
                    exp_req      = 1'b0;
                    exp_tx_valid = 1'b1;
                    exp_tx_data  = wr ? 8'h06 : rdata;
                    break;
                end
                if (c == BT) begin
                    exp_req      = 1'b0;
                    exp_tx_valid = 1'b1;
                    exp_tx_data  = 8'h15;
                    exp_err      = 1'b1;
                end
            end
        end
        for (int k = 0; k < hold; k++) begin
            i_tx_ready = 1'b0;
            tick();
        end
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready   = 1'b0;
        exp_tx_valid = 1'b0;
    endtask

    initial begin
        int e0;
        i_rst = 1'b0; i_rx_data = '0; i_rx_valid = 1'b0; i_tx_ready = 1'b0;
        i_bus_ack = 1'b0; i_bus_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", {7'd0, o_rx_ready}, 8'd1);
        check("rst_tx_valid", {7'd0, o_tx_valid}, 8'd0);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_bus_req", {7'd0, o_bus_req}, 8'd0);
        check("rst_bus_we", {7'd0, o_bus_we}, 8'd0);
        check("rst_bus_addr", o_bus_addr, 8'h00);
        check("rst_bus_wdata", o_bus_wdata, 8'h00);
        check("rst_frame_err", {7'd0, o_frame_err}, 8'd0);
        i_rst  = 1'b1;
        chk_en = 1'b1;
        tick();

        req_cycles = 0;
        run_frame(8'h57, 8'h10, 8'hA5, 3, 8'h00, 0, 0);
        check("wr_we", {7'd0, obs_we}, 8'd1);
        check("wr_addr", obs_addr, 8'h10);
        check("wr_wdata", obs_wdata, 8'hA5);
        check("wr_req_cycles", 8'(req_cycles), 8'd3);
        check("wr_rsp", last_tx, 8'h06);

        run_frame(8'h52, 8'h22, 8'h00, 2, 8'h3C, 5, 0);
        check("rd_we", {7'd0, obs_we}, 8'd0);
        check("rd_addr", obs_addr, 8'h22);
        check("rd_rsp", last_tx, 8'h3C);

        e0 = err_pulses;
        run_frame(8'h41, 8'h00, 8'h00, 1, 8'h00, 1, 0);
        check("bad_rsp", last_tx, 8'h15);
        check("bad_err_pulses", 8'(err_pulses - e0), 8'd1);
        run_frame(8'h52, 8'h01, 8'h00, 1, 8'h77, 0, 0);
        check("after_bad_rsp", last_tx, 8'h77);

        req_cycles = 0;
        e0 = err_pulses;
        run_frame(8'h52, 8'h07, 8'h00, BT + 5, 8'h00, 2, 0);
        check("to_req_cycles", 8'(req_cycles), 8'(BT));
        check("to_rsp", last_tx, 8'h15);
        check("to_err_pulses", 8'(err_pulses - e0), 8'd1);
        req_cycles = 0;
        run_frame(8'h52, 8'h07, 8'h00, BT, 8'h9E, 0, 0);
        check("lastack_req_cycles", 8'(req_cycles), 8'(BT));
        check("lastack_rsp", last_tx, 8'h9E);

        // A partial frame must wait for its next byte (no inter-byte timeout within RXT).
        run_frame(8'h57, 8'h33, 8'h5A, 1, 8'h00, 0, 30);
        check("slow_rsp", last_tx, 8'h06);

        // Reset while the bus request is outstanding: no reply, bridge back to idle.
        send_byte(8'h52);
        send_byte(8'h07);
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 8'h07;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
        exp_req = 1'b0;
        exp_tx_valid = 1'b0;
        #2;
        check("rstbus_state_idle", {7'd0, o_rx_ready}, 8'd1);
        i_rst = 1'b1;
        gap(3);
        run_frame(8'h52, 8'h10, 8'h00, 1, 8'hC3, 0, 0);
        check("post_rst_rsp", last_tx, 8'hC3);

        for (int f = 0; f < 80; f++) begin
            int         sel;
            logic [7:0] cmd;
            sel = $urandom_range(0, 9);
            if (sel < 5) cmd = 8'h57;
            else if (sel < 9) cmd = 8'h52;
            else begin
                cmd = 8'($urandom);
                if (cmd == 8'h57 || cmd == 8'h52) cmd = 8'h00;
            end
            run_frame(cmd, 8'($urandom), 8'($urandom), $urandom_range(1, BT + 2),
                      8'($urandom), $urandom_range(0, 3), 0);
            if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3));
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/uart_regbridge.md
# uart_regbridge

Byte-stream register bridge sitting on the host side of the UART core: consumes received bytes from the UART receive stream, decodes 2- and 3-byte read/write command frames, and performs single register accesses on a simple request/acknowledge bus. Returns one response byte per frame on the UART transmit stream. It is the responder end of the host's command protocol and lets a PC poke on-chip registers through the existing UART.

## Interface
- RX_TIMEOUT, 50000: idle cycles allowed between bytes of one frame (used only with the timeout feature).
- BUS_TIMEOUT, 64: cycles allowed for `i_bus_ack` after `o_bus_req` rises; must be ≥ 2.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset, synchronous, active-low.
- i_rx_data  in  8  received byte from the UART receiver.
- i_rx_valid  in  1  `i_rx_data` valid.
- o_rx_ready  out  1  bridge accepts a byte this cycle.
- o_tx_data  out  8  response byte to the UART transmitter.
- o_tx_valid  out  1  `o_tx_data` valid.
- i_tx_ready  in  1  transmitter accepts the byte.
- o_bus_req  out  1  bus access request, held until ack or timeout.
- o_bus_we  out  1  1 = write, 0 = read; stable while `o_bus_req`.
- o_bus_addr  out  8  register address; stable while `o_bus_req`.
- o_bus_wdata  out  8  write data; stable while `o_bus_req`.
- i_bus_ack  in  1  access complete (one-cycle pulse).
- i_bus_rdata  in  8  read data, sampled on the `i_bus_ack` cycle.
- o_frame_err  out  1  one-cycle pulse on NAK or dropped frame.

## Operation
- Frames: write = 0x57, addr, data; read = 0x52, addr.
- Responses: write OK → 0x06; read OK → read data; unknown command or bus timeout → 0x15.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE, `o_rx_ready`=1: 0x57/0x52 → ADDR, latching `o_bus_we`. Any other byte → RESP with 0x15 and an `o_frame_err` pulse.
- ADDR, `o_rx_ready`=1: on accept, latch `o_bus_addr`; write → DATA, read → BUS.
- DATA, `o_rx_ready`=1: on accept, latch `o_bus_wdata` → BUS.
- BUS, `o_rx_ready`=0: `o_bus_req`=1.
  - `i_bus_ack` → RESP with 0x06 (write) or `i_bus_rdata` (read).
  - No ack within BUS_TIMEOUT cycles → RESP with 0x15 and an `o_frame_err` pulse.
- RESP, `o_tx_valid`=1 with `o_tx_data` stable; `i_tx_ready` → IDLE.
- Byte transfer occurs only when valid && ready on the same edge. Bytes are never lost or duplicated.

## Timing
- Reset values: state IDLE, `o_rx_ready`=1 (in IDLE), `o_tx_valid`=0, `o_tx_data`=0, `o_bus_req`=0, `o_bus_we`=0, `o_bus_addr`=0, `o_bus_wdata`=0, `o_frame_err`=0.
- Reset mid-frame aborts with no response; an in-flight `o_bus_req` drops on the next edge.
- Last frame byte accepted at edge N → `o_bus_req`=1 from cycle N+1.
- `i_bus_ack` at edge M → `o_bus_req`=0 and `o_tx_valid`=1 from cycle M+1.
- Bus timeout counter clears on BUS entry. Timeout fires if no ack is sampled on the BUS_TIMEOUT-th cycle of `o_bus_req`. Ack on that same cycle wins.
- Response accepted at edge K → IDLE, `o_rx_ready`=1 at K+1. Minimum frame turnaround is 1 cycle after response.
- `o_frame_err` is high for exactly the first RESP cycle of a NAK, or the cycle of a drop.
- Input `i_tx_ready` while `o_tx_valid`=0 is ignored. `i_bus_ack` outside BUS is ignored.

## Configuration
- UART_REGBRIDGE_TIMEOUT_EN defined:
  - In ADDR/DATA, count cycles since the last accepted byte.
  - Reaching RX_TIMEOUT → IDLE, no response, `o_frame_err` pulse. This resynchronizes after a lost byte.
  - The counter clears on every accepted byte.
- Undefined: no inter-byte counter. RX_TIMEOUT is unused, and a partial frame waits indefinitely. The bus timeout is always present.

## Structure
- Package `uart_regbridge_pkg`:
  - State enum.
  - CMD_WR=8'h57, CMD_RD=8'h52.
  - RSP_ACK=8'h06, RSP_NAK=8'h15.
- Sub-module `uart_regbridge_tmr`: loadable, clearable cycle counter with a terminal-count flag. One instance serves the bus timeout. A second instance, under the macro, serves the inter-byte timeout.

## Test plan
- Write frame 57 10 A5; ack 3 cycles after req → bus write addr 0x10 data 0xA5 with we=1, then response 0x06.
- Read frame 52 22; ack with rdata 0x3C → we=0, addr 0x22, then response 0x3C. Hold `i_tx_ready` low 5 cycles → `o_tx_valid` and data stay stable throughout.
- Command byte 0x41 → response 0x15 and one `o_frame_err` pulse. Next frame 52 01 → served normally.
- Read 52 07 with no ack → `o_bus_req` held exactly BUS_TIMEOUT cycles, then response 0x15. Ack arriving on the final cycle → read data is returned instead.
- With UART_REGBRIDGE_TIMEOUT_EN and RX_TIMEOUT=100: send 57 10, then idle 100 cycles → IDLE with `o_frame_err` pulse and no tx. Following frame 52 10 → served.
- Assert reset during BUS → `o_bus_req` low and state IDLE on the next edge, with no response byte.
